// File: rtl/uart_multi_lock_control.sv
// uart_multi_lock_control: UART passcode-driven multi-lock controller.
// Optional macro AUTO_RELOCK_EN adds per-lock auto-relock timers.

module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_e;

  rx_st_e      st_q, st_d;
  logic [1:0]  sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        rx;

  assign rx        = sync_q[1];
  assign o_Rx_DV   = dv_q;
  assign o_Rx_Byte = byte_q;

  // State and datapath registers, plus a 2-flop input synchronizer
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      st_q   <= R_IDLE;
      sync_q <= 2'b11;
      cnt_q  <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      sync_q <= {sync_q[0], i_Rx_Serial};
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      dv_q   <= dv_d;
    end
  end

  // Next-state: start bit re-checked at mid-bit to reject glitches
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      R_IDLE:  if (!rx) st_d = R_START;
      R_START: if (cnt_q == HALF) st_d = rx ? R_IDLE : R_DATA;
      R_DATA:  if (cnt_q == LAST && bit_q == 3'd7) st_d = R_STOP;
      R_STOP:  if (cnt_q == LAST) st_d = R_IDLE;
      default: st_d = R_IDLE;
    endcase
  end

  // Datapath: bit-time counter, LSB-first shift, one-cycle valid
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    dv_d   = 1'b0;
    unique case (st_q)
      R_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      R_START: cnt_d = (cnt_q == HALF) ? '0 : cnt_q + CW'(1);
      R_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d         = '0;
          byte_d[bit_q] = rx;
          bit_d         = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          dv_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

endmodule

module uart_multi_lock_control #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int NUM_LOCKS      = 4,
  parameter int CODE_LEN       = 4,
  parameter logic [8*CODE_LEN-1:0] PASSCODE = "1234",
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter int RELOCK_CYCLES  = 500_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  output logic [NUM_LOCKS-1:0] lock_open,
  output logic                 lockout,
  output logic                 fail_pulse,
  output logic [7:0]           debug_rx_byte,
  output logic                 debug_rx_valid
);

  localparam int IW = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
  localparam int DW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_IDX_OPEN, S_GET_IDX_CLOSE, S_GET_CODE, S_LOCKOUT
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DW-1:0]        dig_q, dig_d;
  logic                 mis_q, mis_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 fp_q, fp_d;
  logic [NUM_LOCKS-1:0] lock_q, lock_d;
  logic [NUM_LOCKS-1:0] set_vec, clr_vec, exp_vec;

  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          idx_ok;
  logic [IW-1:0] idx_val;
  logic [7:0]    exp_byte;
  logic          mis_now;
  logic          last_dig;
  logic          max_hit;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_Clock    (clk),
    .i_Reset    (~rst_n),
    .i_Rx_Serial(rx_pin),
    .o_Rx_DV    (rx_dv),
    .o_Rx_Byte  (rx_byte)
  );

  assign debug_rx_byte  = rx_byte;
  assign debug_rx_valid = rx_dv;
  assign lock_open      = lock_q;
  assign lockout        = (state_q == S_LOCKOUT);
  assign fail_pulse     = fp_q;

  assign idx_ok   = (rx_byte >= 8'h30) &&
                    (rx_byte < 8'(8'h30 + NUM_LOCKS));
  assign idx_val  = IW'(rx_byte - 8'h30);
  assign mis_now  = mis_q | (rx_byte != exp_byte);
  assign last_dig = (dig_q == DW'(CODE_LEN - 1));
  assign max_hit  = (fcnt_q == FW'(MAX_FAILS - 1));

  // Passcode byte for the current digit, MSB byte first
  always_comb begin
    exp_byte = '0;
    for (int k = 0; k < CODE_LEN; k++) begin
      if (dig_q == DW'(k)) exp_byte = PASSCODE[8*(CODE_LEN-1-k) +: 8];
    end
  end

  // Control and lock state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dig_q   <= '0;
      mis_q   <= 1'b0;
      fcnt_q  <= '0;
      tmr_q   <= '0;
      fp_q    <= 1'b0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      mis_q   <= mis_d;
      fcnt_q  <= fcnt_d;
      tmr_q   <= tmr_d;
      fp_q    <= fp_d;
      lock_q  <= lock_d;
    end
  end

  // Next-state: full code always consumed before judging it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_dv && rx_byte == 8'h4F) state_d = S_GET_IDX_OPEN;
        if (rx_dv && rx_byte == 8'h43) state_d = S_GET_IDX_CLOSE;
      end
      S_GET_IDX_OPEN:
        if (rx_dv) state_d = idx_ok ? S_GET_CODE : S_IDLE;
      S_GET_IDX_CLOSE:
        if (rx_dv) state_d = S_IDLE;
      S_GET_CODE: begin
        if (rx_dv && last_dig)
          state_d = (mis_now && max_hit) ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT:
        if (tmr_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs/datapath: lock set/clear strobes, fail tally, lockout timer
  always_comb begin
    idx_d   = idx_q;
    dig_d   = dig_q;
    mis_d   = mis_q;
    fcnt_d  = fcnt_q;
    tmr_d   = tmr_q;
    fp_d    = 1'b0;
    set_vec = '0;
    clr_vec = '0;
    unique case (state_q)
      S_GET_IDX_OPEN: begin
        if (rx_dv && idx_ok) begin
          idx_d = idx_val;
          dig_d = '0;
          mis_d = 1'b0;
        end
      end
      S_GET_IDX_CLOSE: begin
        if (rx_dv && idx_ok) clr_vec = NUM_LOCKS'(1) << idx_val;
      end
      S_GET_CODE: begin
        if (rx_dv) begin
          mis_d = mis_now;
          dig_d = dig_q + DW'(1);
          if (last_dig) begin
            dig_d = '0;
            if (mis_now) begin
              fp_d = 1'b1;
              if (max_hit) begin
                fcnt_d = '0;
                tmr_d  = TW'(LOCKOUT_CYCLES - 1);
              end else begin
                fcnt_d = fcnt_q + FW'(1);
              end
            end else begin
              fcnt_d  = '0;
              set_vec = NUM_LOCKS'(1) << idx_q;
            end
          end
        end
      end
      S_LOCKOUT: begin
        if (tmr_q != '0) tmr_d = tmr_q - TW'(1);
      end
      default: ;
    endcase
    lock_d = (lock_q & ~clr_vec & ~exp_vec) | set_vec;
  end

`ifdef AUTO_RELOCK_EN
  localparam int RW = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;

  logic [RW-1:0] rl_q [NUM_LOCKS];
  logic [RW-1:0] rl_d [NUM_LOCKS];

  // Relock timers: reload on every open, expire an open lock at zero
  always_comb begin
    for (int i = 0; i < NUM_LOCKS; i++) begin
      exp_vec[i] = lock_q[i] && (rl_q[i] == '0);
      if (set_vec[i])
        rl_d[i] = RW'(RELOCK_CYCLES - 1);
      else if (rl_q[i] != '0)
        rl_d[i] = rl_q[i] - RW'(1);
      else
        rl_d[i] = '0;
    end
  end

  // Relock timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LOCKS; i++) rl_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LOCKS; i++) rl_q[i] <= rl_d[i];
    end
  end
`else
  assign exp_vec = '0;
`endif

endmodule

// File: tb/tb_uart_multi_lock_control.sv
// tb_uart_multi_lock_control: directed vectors over the UART line.
// Checks lock, fail, lockout, reset and relock behaviour.

module tb_uart_multi_lock_control;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic [3:0] lock_open;
  logic       lockout;
  logic       fail_pulse;
  logic [7:0] dbg_b;
  logic       dbg_v;

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int fp_cnt = 0;
  int lo_rise = 0;
  int lo_fall = 0;
  int t_fall0 = 0;
  int t_post = 0;
  logic [3:0] post_lock;
  logic       post_lo;
  logic       prev_lo = 1'b0;
  logic       prev0 = 1'b0;

  typedef struct {
    string      s;
    logic [3:0] lk;
    int         fp;
    bit         lo;
  } vec_t;

  vec_t tbl [12];

  uart_multi_lock_control #(
    .CLKS_PER_BIT  (CPB),
    .LOCKOUT_CYCLES(200),
    .RELOCK_CYCLES (1000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_pin        (rx_pin),
    .lock_open     (lock_open),
    .lockout       (lockout),
    .fail_pulse    (fail_pulse),
    .debug_rx_byte (dbg_b),
    .debug_rx_valid(dbg_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fail_pulse) fp_cnt++;
    if (!prev_lo && lockout) lo_rise = cyc;
    if (prev_lo && !lockout) lo_fall = cyc;
    prev_lo = lockout;
    if (prev0 && !lock_open[0]) t_fall0 = cyc;
    prev0 = lock_open[0];
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rx_pin = fr[i];
          repeat (CPB) @(negedge clk);
        end
        rx_pin = 1'b1;
        repeat (2 * CPB) @(negedge clk);
      end
      begin
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (dbg_v) begin
            got = 1'b1;
            break;
          end
        end
        if (!got) begin
          ncmp++;
          nerr++;
          $display("FAIL rx_timeout: byte %0h never received", b);
        end else begin
          check("rx_byte", 32'(dbg_b), 32'(b));
          @(negedge clk);
          post_lock = lock_open;
          post_lo   = lockout;
          t_post    = cyc;
        end
      end
    join
  endtask

  task automatic send_seq(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_lock0_low(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (!lock_open[0]) break;
    end
    #1;
  endtask

  initial begin
    int fp0;
    int t0;
    int t1;

    tbl[0]  = '{"O21234", 4'b0100, 0, 1'b0};
    tbl[1]  = '{"O11239", 4'b0100, 1, 1'b0};
    tbl[2]  = '{"O7",     4'b0100, 0, 1'b0};
    tbl[3]  = '{"X",      4'b0100, 0, 1'b0};
    tbl[4]  = '{"O01234", 4'b0101, 0, 1'b0};
    tbl[5]  = '{"C0",     4'b0100, 0, 1'b0};
    tbl[6]  = '{"C0",     4'b0100, 0, 1'b0};
    tbl[7]  = '{"O21234", 4'b0100, 0, 1'b0};
    tbl[8]  = '{"O39234", 4'b0100, 1, 1'b0};
    tbl[9]  = '{"O31235", 4'b0100, 1, 1'b0};
    tbl[10] = '{"C2",     4'b0000, 0, 1'b0};
    tbl[11] = '{"O10000", 4'b0000, 1, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_lock", 32'(lock_open), 32'h0);
    check("rst_lockout", 32'(lockout), 32'h0);
    check("rst_fail", 32'(fail_pulse), 32'h0);
    check("rst_valid", 32'(dbg_v), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      fp0 = fp_cnt;
      send_seq(tbl[i].s);
      check($sformatf("v%0d_lock", i), 32'(post_lock), 32'(tbl[i].lk));
      check($sformatf("v%0d_fails", i), 32'(fp_cnt - fp0),
            32'(tbl[i].fp));
      check($sformatf("v%0d_lockout", i), 32'(post_lo), 32'(tbl[i].lo));
    end

    send_seq("O112");
    check("lo_ignore_lock", 32'(post_lock), 32'h0);
    check("lo_still", 32'(post_lo), 32'h1);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!lockout) break;
    end
    #1;
    check("lockout_len", 32'(lo_fall - lo_rise), 32'd200);
    send_seq("34");
    check("post_lo_tail_lock", 32'(post_lock), 32'h0);
    check("post_lo_tail_lo", 32'(post_lo), 32'h0);
    fp0 = fp_cnt;
    send_seq("O11234");
    check("post_lo_open", 32'(post_lock), 32'h2);
    check("post_lo_open_fp", 32'(fp_cnt - fp0), 32'h0);

    send_seq("O312");
    rst_n = 1'b0;
    #1;
    check("mid_rst_lock", 32'(lock_open), 32'h0);
    check("mid_rst_lockout", 32'(lockout), 32'h0);
    check("mid_rst_fail", 32'(fail_pulse), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_seq("34");
    check("rst_abort", 32'(post_lock), 32'h0);
    send_seq("O31234");
    check("rst_reopen", 32'(post_lock), 32'h8);

`ifdef AUTO_RELOCK_EN
    send_seq("O01234");
    t0 = t_post;
    check("relock_open", 32'(post_lock[0]), 32'h1);
    wait_lock0_low(1500);
    check("relock_len", 32'(t_fall0 - t0), 32'd1000);
    send_seq("O01234");
    t0 = t_post;
    while (cyc < t0 + 450) @(negedge clk);
    check("relock_mid", 32'(lock_open[0]), 32'h1);
    send_seq("O01234");
    t1 = t_post;
    wait_lock0_low(1500);
    check("relock_push", 32'(t_fall0 - t1), 32'd1000);
`else
    send_seq("O01234");
    check("norelock_open", 32'(post_lock), 32'h9);
    repeat (5000) @(negedge clk);
    check("norelock_hold", 32'(lock_open), 32'h9);
    t0 = 0;
    t1 = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
